// File: rtl/bp_fe_queue_buffer.sv
// Checkpointed FE->BE packet queue with speculative reads.
// Entries stay stored until commit so the BE can roll back and replay them.
module bp_fe_queue_buffer #(
   parameter int entry_width_p = 139,
   parameter int els_p         = 8,
   localparam int ptr_width_lp = $clog2(els_p) + 1
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [entry_width_p-1:0] fe_queue_i,
   input  logic                     fe_queue_v_i,
   output logic                     fe_queue_ready_o,
   output logic [entry_width_p-1:0] fe_queue_o,
   output logic                     fe_queue_v_o,
   input  logic                     fe_queue_yumi_i,
   input  logic                     commit_v_i,
   input  logic                     roll_v_i,
   input  logic                     clr_v_i
);

   localparam int idx_w_lp = ptr_width_lp - 1;
   localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

   logic [entry_width_p-1:0] r_mem [els_p];
   logic [ptr_width_lp-1:0]  r_wptr;
   logic [ptr_width_lp-1:0]  r_rptr;
   logic [ptr_width_lp-1:0]  r_cptr;

   logic                     w_full;
   logic                     w_enq;
   logic [ptr_width_lp-1:0]  w_cptr_inc;

   // Space is counted from the commit pointer: read entries still occupy slots
   assign w_full = (r_wptr[idx_w_lp-1:0] == r_cptr[idx_w_lp-1:0])
                 & (r_wptr[idx_w_lp] != r_cptr[idx_w_lp]);

   assign fe_queue_ready_o = ~w_full;
   assign w_enq            = fe_queue_v_i & ~w_full & ~clr_v_i;
   assign fe_queue_v_o     = (r_rptr != r_wptr);
   assign fe_queue_o       = r_mem[r_rptr[idx_w_lp-1:0]];
   assign w_cptr_inc       = r_cptr + ptr_one_lp;

   // Pointer update: clear beats roll, roll beats plain dequeue
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cptr <= '0;
      end else begin
         if (w_enq) begin
            r_wptr <= r_wptr + ptr_one_lp;
         end
         if (clr_v_i) begin
            r_rptr <= r_wptr;
            r_cptr <= r_wptr;
         end else if (roll_v_i) begin
            if (commit_v_i) begin
               r_cptr <= w_cptr_inc;
               r_rptr <= w_cptr_inc;
            end else begin
               r_rptr <= r_cptr;
            end
         end else begin
            if (fe_queue_yumi_i) begin
               r_rptr <= r_rptr + ptr_one_lp;
            end
            if (commit_v_i) begin
               r_cptr <= w_cptr_inc;
            end
         end
      end
   end

   // Packet storage, intentionally not reset
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_mem[r_wptr[idx_w_lp-1:0]] <= fe_queue_i;
      end
   end

   a_yumi_valid : assert property (
      @(posedge clk_i) disable iff (!reset_n_i)
      (fe_queue_yumi_i & ~roll_v_i & ~clr_v_i) |-> fe_queue_v_o
   );

   a_commit_read : assert property (
      @(posedge clk_i) disable iff (!reset_n_i)
      (commit_v_i & ~clr_v_i) |-> (r_cptr != r_rptr)
   );

endmodule
